// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: branch condition codes and the branch controller state encoding.
package rv32_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

endpackage

// File: rtl/branch_ctrl.sv
// EX-stage branch/jump resolution: checks the BTFN prediction, issues a PC redirect and a timed
// front-end flush on mispredict, and counts resolved transfers and redirects.
module branch_ctrl
    import rv32_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic [2:0]       ex_funct3,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_imm,
    input  logic [31:0]      ex_rs1,
    input  logic             ex_pred_taken,
    output logic             cmp_en,
    output logic [2:0]       cmp_op,
    input  logic             cmp_taken,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_front,
    output logic             misalign_exc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam bit         HAS_FLUSH  = (FLUSH_CYCLES > 1);
    localparam logic [2:0] FLUSH_LOAD = HAS_FLUSH ? 3'(FLUSH_CYCLES - 2) : 3'd0;

    state_t            r_state;
    logic [2:0]        r_flush_cnt;
    logic              r_redirect_valid;
    logic [31:0]       r_redirect_pc;
    logic              r_flush_front;
    logic              r_misalign_exc;
    logic [CNT_W-1:0]  r_branch_cnt;
    logic [CNT_W-1:0]  r_mispred_cnt;

    logic              w_acc;
    logic              w_taken;
    logic              w_pred;
    logic              w_mispred;
    logic [31:0]       w_target;
    logic [31:0]       w_fix_pc;

    // Resolve the EX control transfer: accept, outcome, target and corrected fetch address.
    always_comb begin
        w_acc     = 1'b0;
        w_taken   = 1'b0;
        w_pred    = 1'b0;
        w_target  = 32'd0;
        w_fix_pc  = 32'd0;
        w_mispred = 1'b0;
        if (r_state == IDLE) begin
            w_acc = ex_valid & ~stall & (ex_is_branch | ex_is_jal | ex_is_jalr);
        end else begin
            w_acc = 1'b0;
        end
        w_taken = ex_is_jal | ex_is_jalr | (ex_is_branch & cmp_taken);
        // JALR has no usable IF prediction, so it always counts as predicted not-taken.
        w_pred  = ex_pred_taken & ~ex_is_jalr;
        if (ex_is_jalr) begin
            w_target = (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
        end else begin
            w_target = ex_pc + ex_imm;
        end
        if (w_taken) begin
            w_fix_pc = w_target;
        end else begin
            w_fix_pc = ex_pc + 32'd4;
        end
        w_mispred = (w_taken != w_pred);
    end

    // Comparator drive is valid only for an accepted conditional branch.
    always_comb begin
        cmp_en = w_acc & ex_is_branch;
        cmp_op = ex_funct3;
    end

    // Redirect/flush FSM with registered outputs and performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_flush_cnt      <= 3'd0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_flush_front    <= 1'b0;
            r_misalign_exc   <= 1'b0;
            r_branch_cnt     <= '0;
            r_mispred_cnt    <= '0;
        end else begin
            r_redirect_valid <= 1'b0;
            r_misalign_exc   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
                        if (w_mispred && w_fix_pc[1]) begin
                            r_misalign_exc <= 1'b1;
                        end else if (w_mispred) begin
                            r_redirect_valid <= 1'b1;
                            r_redirect_pc    <= w_fix_pc;
                            r_flush_front    <= 1'b1;
                            r_mispred_cnt    <= r_mispred_cnt + CNT_W'(1);
                            r_state          <= REDIRECT;
                        end
                    end
                end
                REDIRECT: begin
                    if (HAS_FLUSH) begin
                        r_state     <= FLUSH;
                        r_flush_cnt <= FLUSH_LOAD;
                    end else begin
                        r_state       <= IDLE;
                        r_flush_front <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (!stall) begin
                        if (r_flush_cnt == 3'd0) begin
                            r_state       <= IDLE;
                            r_flush_front <= 1'b0;
                        end else begin
                            r_flush_cnt <= r_flush_cnt - 3'd1;
                        end
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_flush_front <= 1'b0;
                end
            endcase
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush_front    = r_flush_front;
    assign misalign_exc   = r_misalign_exc;
    assign branch_cnt     = r_branch_cnt;
    assign mispred_cnt    = r_mispred_cnt;

endmodule
